vga_pixel_stream_in: RTL and testbench

- Pixel-input stage between the upstream pixel producer and the VGA colour output path.
- Buffers multi-channel pixels arriving on a valid/ready stream.
- Releases exactly one pixel per timing-generator request during the active area.
- Substitutes blank pixels on underflow, and flushes and re-arms at every frame start.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_sync_fifo.sv | 58 +++++
 rtl/vga_pixel_stream_in.sv | 108 ++++++++++
 tb/tb_vga_pixel_stream_in.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared pixel-format definitions for the VGA pixel input path.
// Channel k of a pixel word sits at bits [k*CH_WIDTH +: CH_WIDTH].
package vga_pkg;

  localparam int CHANNELS   = 3;
  localparam int CH_WIDTH   = 4;
  localparam int DATA_WIDTH = CHANNELS * CH_WIDTH;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic {MODE_RGB, MODE_GREY} vga_mode_e;

  localparam logic [CH_WIDTH-1:0] BLANK     = '0;
  localparam pixel_t              BLANK_PIX = {CHANNELS{BLANK}};

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a synchronous flush.
// The head word is presented combinationally on rdata.
module vga_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign rdata = mem_q[rd_q[AW-1:0]];

  // Flush wins over any push/pop issued in the same cycle.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full)  wr_d = wr_q + 1'b1;
      if (pop  && !empty) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries data only; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vga_pixel_stream_in.sv
// Buffers incoming pixels and releases one per timing request, inserting
// blank pixels on underflow; each frame start flushes and latches the mode.
module vga_pixel_stream_in
  import vga_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       pix_req,
  input  logic                       frame_start,
  input  logic                       mode,
  output logic [DATA_WIDTH-1:0]      rgb_out,
  output logic                       rgb_valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       underflow,
  output logic [CNT_WIDTH-1:0]       underflow_cnt
);

  function automatic pixel_t fmt_pixel(input pixel_t p, input vga_mode_e m);
    pixel_t r;
    r = p;
    if (m == MODE_GREY) begin
      for (int k = 0; k < CHANNELS; k++) r[k*CH_WIDTH +: CH_WIDTH] = p[CH_WIDTH-1:0];
    end
    return r;
  endfunction

  logic      fifo_full, fifo_empty, push, pop;
  pixel_t    head;
  vga_mode_e mode_q, mode_d;
  pixel_t    rgb_q, rgb_d;
  logic      vld_q, vld_d;
  logic      unf_q, unf_d;
  logic      rdy_en_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // rdy_en_q keeps the producer stalled until the first edge after reset.
  assign in_ready = rdy_en_q && !fifo_full && !frame_start;
  assign push     = in_valid && in_ready;
  assign pop      = pix_req && !fifo_empty && !frame_start;

  vga_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    mode_d = mode_q;
    rgb_d  = rgb_q;
    vld_d  = 1'b0;
    unf_d  = unf_q;
    cnt_d  = cnt_q;
    if (frame_start) begin
      mode_d = vga_mode_e'(mode);
      rgb_d  = BLANK_PIX;
      unf_d  = 1'b0;
    end else if (pix_req) begin
      if (!fifo_empty) begin
        rgb_d = fmt_pixel(head, mode_q);
        vld_d = 1'b1;
      end else begin
        rgb_d = BLANK_PIX;
        unf_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_RGB;
      rgb_q    <= BLANK_PIX;
      vld_q    <= 1'b0;
      unf_q    <= 1'b0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      rgb_q    <= rgb_d;
      vld_q    <= vld_d;
      unf_q    <= unf_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign rgb_out       = rgb_q;
  assign rgb_valid     = vld_q;
  assign underflow     = unf_q;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_vga_pixel_stream_in.sv
// Directed bench for vga_pixel_stream_in with hand-computed expectations.
module tb_vga_pixel_stream_in;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        pix_req = 1'b0;
  logic        frame_start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] rgb_out;
  logic        rgb_valid;
  logic [4:0]  level;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int pass_cnt = 0;
  int total    = 0;

  vga_pixel_stream_in #(.DEPTH(16), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .pix_req       (pix_req),
    .frame_start   (frame_start),
    .mode          (mode),
    .rgb_out       (rgb_out),
    .rgb_valid     (rgb_valid),
    .level         (level),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, observed before any clock edge.
    #2;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_vld", 32'(rgb_valid), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_cnt", 32'(underflow_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(in_ready), 0);
    tick();
    chk("rdy_after_edge", 32'(in_ready), 1);

    // Three pushes, then three pops with 1-cycle latency.
    in_valid = 1'b1;
    in_data = 12'h123; tick();
    in_data = 12'h456; tick();
    in_data = 12'h789; tick();
    in_valid = 1'b0;
    chk("lvl3", 32'(level), 3);
    pix_req = 1'b1;
    tick(); chk("pop0", 32'(rgb_out), 32'h123); chk("pop0_v", 32'(rgb_valid), 1); chk("pop0_l", 32'(level), 2);
    tick(); chk("pop1", 32'(rgb_out), 32'h456); chk("pop1_v", 32'(rgb_valid), 1); chk("pop1_l", 32'(level), 1);
    tick(); chk("pop2", 32'(rgb_out), 32'h789); chk("pop2_v", 32'(rgb_valid), 1); chk("pop2_l", 32'(level), 0);

    // Five underflows.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("unf_rgb", 32'(rgb_out), 0);
      chk("unf_vld", 32'(rgb_valid), 0);
    end
    pix_req = 1'b0;
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_cnt5", 32'(underflow_cnt), 5);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("fs_unf_clr", 32'(underflow), 0);
    chk("fs_cnt_kept", 32'(underflow_cnt), 5);

    // Fill to full, stall the 17th word, free one slot.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 12'hA00 + 12'(i);
      tick();
    end
    chk("full_lvl", 32'(level), 16);
    chk("full_rdy", 32'(in_ready), 0);
    in_data = 12'hBBB;
    tick();
    chk("stall_lvl", 32'(level), 16);
    pix_req = 1'b1; tick(); pix_req = 1'b0;
    chk("full_pop", 32'(rgb_out), 32'hA00);
    chk("full_pop_l", 32'(level), 15);
    chk("rdy_rise", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("w17_lvl", 32'(level), 16);
    chk("w17_rdy", 32'(in_ready), 0);
    pix_req = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("drain", 32'(rgb_out), 32'hA00 + 32'(i));
    end
    tick();
    pix_req = 1'b0;
    chk("drain_w17", 32'(rgb_out), 32'hBBB);
    chk("drain_lvl", 32'(level), 0);

    // Grey mode latched at frame start; mid-frame change ignored.
    mode = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    in_valid = 1'b1; in_data = 12'h3A5; tick(); in_valid = 1'b0;
    pix_req = 1'b1; tick(); pix_req = 1'b0;
    chk("grey", 32'(rgb_out), 32'h555);
    mode = 1'b0;
    in_valid = 1'b1; in_data = 12'h1B7; tick(); in_valid = 1'b0;
    pix_req = 1'b1; tick(); pix_req = 1'b0;
    chk("grey_hold", 32'(rgb_out), 32'h777);

    // Flush with level 7 and a coincident request; mode 0 latched here.
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 12'h201 + 12'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("lvl7", 32'(level), 7);
    frame_start = 1'b1; pix_req = 1'b1; tick(); frame_start = 1'b0; pix_req = 1'b0;
    chk("flush_lvl", 32'(level), 0);
    chk("flush_vld", 32'(rgb_valid), 0);
    chk("flush_rgb", 32'(rgb_out), 0);
    chk("flush_unf", 32'(underflow), 0);
    chk("flush_cnt", 32'(underflow_cnt), 5);
    in_valid = 1'b1; in_data = 12'h3A5; tick(); in_valid = 1'b0;
    pix_req = 1'b1; tick(); pix_req = 1'b0;
    chk("rgb_mode", 32'(rgb_out), 32'h3A5);

    // Streaming: push and pop every cycle from level 1.
    in_valid = 1'b1; in_data = 12'h400; tick();
    pix_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 12'h500 + 12'(i);
      tick();
      chk("stream", 32'(rgb_out), (i == 0) ? 32'h400 : 32'h500 + 32'(i - 1));
      chk("stream_lvl", 32'(level), 1);
    end

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #2;
    chk("arst_lvl", 32'(level), 0);
    chk("arst_rgb", 32'(rgb_out), 0);
    chk("arst_vld", 32'(rgb_valid), 0);
    chk("arst_unf", 32'(underflow), 0);
    chk("arst_cnt", 32'(underflow_cnt), 0);
    chk("arst_rdy", 32'(in_ready), 0);
    in_valid = 1'b0; pix_req = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
